// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq
//   Sequencer for the DLFloat16 MAC datapath (1b sign, 6b exp bias 31, 9b mantissa).
//   Runs one dot product of programmable length. It clears the MAC, then streams
//   operand pairs in over a valid/ready handshake. Once the MAC pipeline has drained,
//   it presents the accumulated sum over a valid/ready handshake.
//
// Parameters
//   LEN_W     width of vec_len and the element counter (max length 2^LEN_W-1)
//   MAC_LAT   MAC cycles from operand at mac_a/mac_b to updated accumulator
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start, vec_len        launch request and pair count, sampled only in IDLE
//   busy                  high whenever the sequencer is not idle
//   op_valid/op_ready     operand pair handshake; op_a/op_b are the pair
//   mac_a, mac_b          registered operands to the MAC (zero when no pair)
//   mac_rst_n             registered active-low clear to the MAC
//   mac_acc               MAC accumulator output
//   res_valid/res_ready   result handshake; res_data is the captured sum,
//                         res_err flags the NaN/inf code 16'hFFFF
module dlfloat_mac_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_rst_n,
  input  logic [15:0]      mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_err
);

  // Drain counter must hold 0..MAC_LAT; the +2 keeps the width nonzero for MAC_LAT=0.
  localparam int DW = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state, next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] elem_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             accept;
  logic             last_elem;
  logic             drain_last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    op_ready   = (state == RUN);
    accept     = op_valid && (state == RUN);
    last_elem  = accept && (elem_cnt == len_q - LEN_W'(1));
    drain_last = (state == DRAIN) && (drain_cnt == DW'(MAC_LAT));
    case (state)
      IDLE:    if (start) next_state = (vec_len != '0) ? CLEAR : DONE;
      CLEAR:   next_state = RUN;
      RUN:     if (last_elem) next_state = DRAIN;
      DRAIN:   if (drain_last) next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The MAC is held in clear outside RUN/DRAIN, so every run starts from a zero
  // accumulator. Cycles without an accepted pair feed zeros, whose product
  // leaves the accumulator unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mac_a     <= '0;
      mac_b     <= '0;
      mac_rst_n <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      len_q     <= '0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      mac_rst_n <= (next_state == RUN) || (next_state == DRAIN);
      mac_a     <= accept ? op_a : 16'h0000;
      mac_b     <= accept ? op_b : 16'h0000;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= vec_len;
            elem_cnt <= '0;
            if (vec_len == '0) begin
              res_data  <= 16'h0000;
              res_err   <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept)    elem_cnt  <= elem_cnt + LEN_W'(1);
          if (last_elem) drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_last) begin
            res_data  <= mac_acc;
            res_err   <= (mac_acc == 16'hFFFF);
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// tb_dlfloat_mac_seq
//   Directed bench for dlfloat_mac_seq. A small behavioural DLFloat16 MAC
//   (two-stage multiply then accumulate, sticky NaN code) sits on the MAC
//   side so the sequencer sees realistic accumulator timing.
module tb_dlfloat_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_rst_n;
  logic [15:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  dlfloat_mac_seq #(.LEN_W(8), .MAC_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_len   (vec_len),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_rst_n (mac_rst_n),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  // DLFloat16 decode/encode for exactly representable values.
  function automatic real to_real(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] to_dl(input real v);
    real  r;
    logic s;
    int   e;
    int   m;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 31;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    m = $rtoi((r - 1.0) * 512.0);
    return {s, 6'(e), 9'(m)};
  endfunction

  // Behavioural MAC: product registered on the first edge, accumulated on the second.
  real  prod_r = 0.0;
  real  acc_r  = 0.0;
  logic prod_nan = 1'b0;
  logic acc_nan  = 1'b0;

  always @(posedge clk) begin
    if (!mac_rst_n) begin
      prod_r   <= 0.0;
      acc_r    <= 0.0;
      prod_nan <= 1'b0;
      acc_nan  <= 1'b0;
    end else begin
      prod_r   <= to_real(mac_a) * to_real(mac_b);
      prod_nan <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
      acc_r    <= acc_r + prod_r;
      acc_nan  <= acc_nan | prod_nan;
    end
  end

  assign mac_acc = acc_nan ? 16'hFFFF : to_dl(acc_r);

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] len, input logic v,
                               input logic [15:0] a, input logic [15:0] b, input logic rr);
    start     = s;
    vec_len   = len;
    op_valid  = v;
    op_a      = a;
    op_b      = b;
    res_ready = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits for res_valid within a cycle budget, then checks it arrived at the expected cycle.
  task automatic waitResult(input string tag, input int budget, input int exp_cyc);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick(); tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'h0);
    checkOutput("rst_res_err", 32'(res_err), 32'd0);
    checkOutput("rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
    checkOutput("rst_mac_a", 32'(mac_a), 32'h0);
    checkOutput("rst_op_ready", 32'(op_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // op_valid while idle must not be accepted
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h4000, 16'h4000, 1'b0);
    tick(); tick();
    checkOutput("idle_op_ready", 32'(op_ready), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_mac_a", 32'(mac_a), 32'h0);

    // Test 1: N=3, 1.0*1.0 three times, no stalls, start pulses mid-run ignored
    $display("[TB] test 1: N=3 no stalls");
    applyStimulus(1'b1, 8'd3, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    cyc = 0;
    tick();
    checkOutput("t1_clear_busy", 32'(busy), 32'd1);
    checkOutput("t1_clear_op_ready", 32'(op_ready), 32'd0);
    checkOutput("t1_clear_mac_rst_n", 32'(mac_rst_n), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    tick();
    checkOutput("t1_run_op_ready", 32'(op_ready), 32'd1);
    checkOutput("t1_run_mac_rst_n", 32'(mac_rst_n), 32'd1);
    tick();
    checkOutput("t1_mac_a", 32'(mac_a), 32'h3E00);
    applyStimulus(1'b1, 8'd5, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    tick();
    checkOutput("t1_drain_op_ready", 32'(op_ready), 32'd0);
    checkOutput("t1_last_mac_b", 32'(mac_b), 32'h3E00);
    applyStimulus(1'b1, 8'd5, 1'b0, 16'h1234, 16'h1234, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h1234, 16'h1234, 1'b0);
    checkOutput("t1_drain_bubble", 32'(mac_a), 32'h0);
    waitResult("t1", 20, 8);
    checkOutput("t1_res_data", 32'(res_data), 32'h4100);
    checkOutput("t1_res_err", 32'(res_err), 32'd0);
    applyStimulus(1'b1, 8'd4, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_hold_valid", 32'(res_valid), 32'd1);
    applyStimulus(1'b1, 8'd4, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("t1_ack_valid", 32'(res_valid), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_no_relaunch", 32'(busy), 32'd0);

    // Test 2: N=2, 1.0*2.0 twice with a two-cycle gap -> 4.0
    $display("[TB] test 2: N=2 with stalls");
    applyStimulus(1'b1, 8'd2, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc = 0;
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h4000, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h5555, 16'h5555, 1'b0);
    tick();
    checkOutput("t2_stall_bubble", 32'(mac_a), 32'h0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h4000, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("t2_drain_op_ready", 32'(op_ready), 32'd0);
    waitResult("t2", 20, 9);
    checkOutput("t2_res_data", 32'(res_data), 32'h4200);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("t2_ack_valid", 32'(res_valid), 32'd0);

    // Test 3: zero-length vector goes straight to DONE and holds without res_ready
    $display("[TB] test 3: vec_len=0");
    applyStimulus(1'b1, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("t3_valid", 32'(res_valid), 32'd1);
    checkOutput("t3_res_data", 32'(res_data), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t3_held_valid", 32'(res_valid), 32'd1);
    checkOutput("t3_held_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("t3_ack_valid", 32'(res_valid), 32'd0);

    // Test 4: NaN/inf code propagates to res_err
    $display("[TB] test 4: NaN operand");
    applyStimulus(1'b1, 8'd2, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc = 0;
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'hFFFF, 16'h3E00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    waitResult("t4", 20, 7);
    checkOutput("t4_res_data", 32'(res_data), 32'hFFFF);
    checkOutput("t4_res_err", 32'(res_err), 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();

    // Test 5: reset mid-run aborts, then a fresh N=1 run works
    $display("[TB] test 5: reset during RUN");
    applyStimulus(1'b1, 8'd3, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h3E00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
    checkOutput("t5_rst_mac_a", 32'(mac_a), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    checkOutput("t5_no_result", 32'(seen), 32'd0);
    applyStimulus(1'b1, 8'd1, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc = 0;
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h4000, 16'h4000, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    waitResult("t5", 20, 6);
    checkOutput("t5_res_data", 32'(res_data), 32'h4200);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();

    // Test 7: maximum length 255 must finish without counter wrap
    $display("[TB] test 7: vec_len=255");
    applyStimulus(1'b1, 8'd255, 1'b1, 16'h3E00, 16'h0000, 1'b0);
    cyc = 0;
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h3E00, 16'h0000, 1'b0);
    waitResult("t7", 400, 260);
    checkOutput("t7_res_data", 32'(res_data), 32'h0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("t7_ack_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
